sram_sample_reader: RTL



---
 rtl/sram_sample_reader_if.sv | 28 ++
 rtl/sram_sample_reader.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sram_sample_reader_if.sv
// Control, SRAM read port and output stream of the sample reader.
interface sram_sample_reader_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          start_i;
    logic          abort_i;
    logic [AW-1:0] base_addr_i;
    logic [AW:0]   count_i;
    logic          mem_renb_o;
    logic [AW-1:0] mem_raddr_o;
    logic [DW-1:0] mem_data_i;
    logic [DW-1:0] dout_o;
    logic          dout_valid_o;
    logic          dout_ready_i;
    logic          busy_o;
    logic          done_o;

    modport slave (
        input  start_i, abort_i, base_addr_i, count_i, mem_data_i, dout_ready_i,
        output mem_renb_o, mem_raddr_o, dout_o, dout_valid_o, busy_o, done_o
    );

    modport master (
        output start_i, abort_i, base_addr_i, count_i, mem_data_i, dout_ready_i,
        input  mem_renb_o, mem_raddr_o, dout_o, dout_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/sram_sample_reader.sv
// Streams a block of words out of the sample SRAM read port, hiding the
// one-cycle read latency behind a small credit-managed output FIFO.
module sram_sample_reader #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 2
) (
    input logic                 wb_clk_i,
    input logic                 wb_rst_n_i,
    sram_sample_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0] MAX_WORDS = {1'b1, {AW{1'b0}}};

    state_t        state;
    logic [AW-1:0] addr;
    logic [AW:0]   remaining;
    logic          inflight;
    logic [DW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [OW-1:0] occ, occ_next;
    logic [OW:0]   used;
    logic          busy, done;
    logic          push, pop, issue, launch, aborting;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop      = (occ != '0) && bus.dout_ready_i;
    assign push     = inflight;
    assign occ_next = occ + OW'(push) - OW'(pop);
    // A word popped this cycle frees its slot in time for a same-cycle issue.
    assign used     = {1'b0, occ} + (OW+1)'(inflight) - (OW+1)'(pop);
    assign aborting = bus.abort_i && (state == READ || state == DRAIN);
    assign launch   = bus.start_i && (state == IDLE || state == DONE);
    assign issue    = (state == READ) && (remaining != '0) && !bus.abort_i &&
                      (used < (OW+1)'(FIFO_DEPTH));

    assign bus.mem_renb_o   = !issue;
    assign bus.mem_raddr_o  = addr;
    assign bus.dout_o       = fifo_mem[rd_ptr];
    assign bus.dout_valid_o = (occ != '0);
    assign bus.busy_o       = busy;
    assign bus.done_o       = done;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occ       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (aborting) begin
                // The flush also swallows any word returning this cycle.
                rd_ptr <= '0;
                wr_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) begin
                    fifo_mem[wr_ptr] <= bus.mem_data_i;
                    wr_ptr           <= ptr_inc(wr_ptr);
                end
                if (pop) rd_ptr <= ptr_inc(rd_ptr);
                occ <= occ_next;
            end
            if (issue) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (launch) begin
                        addr      <= bus.base_addr_i;
                        remaining <= (bus.count_i > MAX_WORDS) ? MAX_WORDS : bus.count_i;
                        if (bus.count_i == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (aborting) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (issue && remaining == (AW+1)'(1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (aborting || occ_next == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_n_i) assert (!(push && !pop && occ == OW'(FIFO_DEPTH)));
    end
endmodule
